sp_ram_param: RTL and testbench
===============================

Name: sp_ram_param

Overview:
- Parametrised single-port synchronous RAM. Successor to the fixed 8x64 single-port RAM.
- Adds configurable width and depth, byte-lane write enables, selectable read-during-write mode, and an optional output register stage.
- Adds a hardware clear sequencer that zeroes the whole array after reset.
- Used as the general scratch/buffer memory in datapath blocks.

Parameters:
DATA_WIDTH, 8, word width in bits; must be a multiple of 8.
ADDR_WIDTH, 6, address width; DEPTH = 2**ADDR_WIDTH words.
RD_MODE, 0, read-during-write behaviour: 0 = read-first (old data), 1 = write-first (new data), 2 = no-change (q not updated on write).
OUT_REG, 0, 0 = 1-cycle read latency; 1 = extra output register, 2-cycle latency.
CLEAR_ON_RESET, 1, 1 = zero all words after reset; 0 = no clear, array contents undefined.

Ports:
clk  input  1  clock; all logic acts on its rising edge.
rst  input  1  synchronous, active-high reset.
en  input  1  access request for this cycle.
we  input  1  write enable; qualified by en.
be  input  DATA_WIDTH/8  byte-lane write enables; bit i controls data[8i+7:8i].
addr  input  ADDR_WIDTH  word address.
data  input  DATA_WIDTH  write data.
q  output  DATA_WIDTH  read data.
q_valid  output  1  one-cycle pulse marking new data on q.
busy  output  1  high while the clear sequence runs; accesses are ignored while high.

Behaviour:
- Reset (rst high at a clk edge):
  - q=0, q_valid=0, pipeline registers cleared.
  - CLEAR_ON_RESET=1: busy=1, FSM enters CLEAR with clear counter = 0.
  - CLEAR_ON_RESET=0: busy=0, FSM enters IDLE.
- FSM states: CLEAR and IDLE.
  - CLEAR: writes 0 to word [counter] each cycle, then increments the counter.
  - After writing word DEPTH-1, FSM goes to IDLE and busy drops on the next edge. busy is high for exactly DEPTH cycles after reset release.
  - rst asserted during CLEAR restarts the sequence from word 0.
  - IDLE: no exit except rst.
- Accepted access: en=1 and busy=0. While busy=1, en/we are ignored: no write and no q_valid.
- Write (accepted, we=1):
  - Byte lane i is updated only if be[i]=1; other lanes keep their old value.
  - be=0 performs no write but still counts as an access for RD_MODE.
- Read (accepted, we=0): q shows mem[addr] as sampled at the access edge.
- Read-during-write output (accepted, we=1):
  - RD_MODE=0: q shows the pre-write word.
  - RD_MODE=1: q shows the post-write merged word.
  - RD_MODE=2: q holds its previous value and q_valid stays low.
- Latency:
  - Access at edge N: q and q_valid update at edge N+1 when OUT_REG=0, or at edge N+2 when OUT_REG=1.
  - q_valid is high for one cycle per access. Back-to-back accesses give one result per cycle (fully pipelined).
- q holds its last value when no valid result is produced; it is not cleared to 0 between accesses.
- Addressing: addr is always in range (DEPTH = 2**ADDR_WIDTH). No wrap or error logic.
- Pipeline flush: rst flushes in-flight results; no q_valid is produced for accesses accepted before reset.
- Implementation: the array must stay inferable as block RAM, with a single synchronous read port. Per-lane write enables are generated from be.

Test Plan:
- Clear: DATA_WIDTH=16, ADDR_WIDTH=4. Pulse rst for 1 cycle -> busy high for exactly 16 cycles. Then read all 16 addresses -> every q=0x0000, one q_valid per read.
- Byte enables: write addr 3, data 0xABCD, be=2'b11. Then write addr 3, data 0x1234, be=2'b01. Then read addr 3 -> q=0xAB34.
- Read-during-write: mem[5]=0x1111. Write 0x2222 to addr 5, be=11:
  - RD_MODE=0 -> q=0x1111, q_valid=1.
  - RD_MODE=1 -> q=0x2222.
  - RD_MODE=2 -> q unchanged, q_valid=0.
- Latency/throughput: OUT_REG=1, reads of addr 0,1,2 on three consecutive edges -> results at edges +2, +3, +4, with three consecutive q_valid pulses.
- Busy lockout: issue write addr 0, data 0xFFFF during CLEAR -> ignored; after clear, read addr 0 -> q=0x0000.
- Reset mid-clear: assert rst at clear cycle 7 -> busy stays high for 16 more cycles; a read issued during the OUT_REG pipeline when rst hits produces no q_valid.

Source files
------------

// File: rtl/sp_ram_param.sv
`default_nettype none
// ============================================================================
// Module   : sp_ram_param
// Brief    : Parametrised single-port synchronous RAM with byte-lane writes,
//            selectable read-during-write mode, optional output register and
//            a post-reset clear sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module sp_ram_param #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 6,
    parameter int RD_MODE        = 0,
    parameter int OUT_REG        = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      we,
    input  logic [DATA_WIDTH/8-1:0]   be,
    input  logic [ADDR_WIDTH-1:0]     addr,
    input  logic [DATA_WIDTH-1:0]     data,
    output logic [DATA_WIDTH-1:0]     q,
    output logic                      q_valid,
    output logic                      busy
);

    localparam int c_DEPTH = 2 ** ADDR_WIDTH;
    localparam int c_LANES = DATA_WIDTH / 8;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [ADDR_WIDTH-1:0]   r_clr_cnt;
    logic [ADDR_WIDTH-1:0]   w_clr_cnt_next;
    logic                    w_clr_we;

    logic                    w_busy;
    logic                    w_acc;
    logic                    w_wr;
    logic [c_LANES-1:0]      w_lane_we;
    logic [ADDR_WIDTH-1:0]   w_waddr;
    logic [DATA_WIDTH-1:0]   w_wdata;

    logic [DATA_WIDTH-1:0]   r_mem [c_DEPTH];
    logic [DATA_WIDTH-1:0]   r_rd_word;

    logic                    r_s1_valid;
    logic                    r_s1_merge;
    logic [c_LANES-1:0]      r_s1_be;
    logic [DATA_WIDTH-1:0]   r_s1_data;
    logic [DATA_WIDTH-1:0]   w_s1_word;

    logic                    r_s2_valid;
    logic [DATA_WIDTH-1:0]   r_s2_q;

    // ------------------------------------------------------------------------
    // Clear sequencer
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;
            r_clr_cnt <= '0;
        end else begin
            r_state   <= w_state_next;
            r_clr_cnt <= w_clr_cnt_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_clr_cnt_next = r_clr_cnt;
        w_clr_we       = 1'b0;
        case (r_state)
            S_CLEAR: begin
                w_clr_we       = 1'b1;
                w_clr_cnt_next = r_clr_cnt + ADDR_WIDTH'(1);
                if (&r_clr_cnt) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign w_busy = (r_state == S_CLEAR);
    assign busy   = w_busy;

    // ------------------------------------------------------------------------
    // Write port: the clear sequencer owns the port while busy
    // ------------------------------------------------------------------------
    assign w_acc   = en & ~w_busy;
    assign w_wr    = w_acc & we;
    assign w_waddr = w_clr_we ? r_clr_cnt : addr;
    assign w_wdata = w_clr_we ? '0 : data;

    for (genvar i = 0; i < c_LANES; i++) begin : g_lane_we
        assign w_lane_we[i] = w_clr_we | (w_wr & be[i]);
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < c_LANES; i++) begin
            if (w_lane_we[i]) begin
                r_mem[w_waddr][i*8 +: 8] <= w_wdata[i*8 +: 8];
            end
        end
    end

    // Single synchronous read port; always returns the pre-write word.
    always_ff @(posedge clk) begin
        if (w_acc) begin
            r_rd_word <= r_mem[addr];
        end
    end

    // ------------------------------------------------------------------------
    // Result pipeline
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_merge <= 1'b0;
            r_s1_be    <= '0;
            r_s1_data  <= '0;
        end else begin
            r_s1_valid <= w_acc & ~(we & (RD_MODE == 2));
            r_s1_merge <= w_wr & (RD_MODE == 1);
            r_s1_be    <= be;
            r_s1_data  <= data;
        end
    end

    // Write-first is rebuilt from the old word plus the captured write lanes,
    // keeping the array free of any combinational read path.
    for (genvar i = 0; i < c_LANES; i++) begin : g_merge
        assign w_s1_word[i*8 +: 8] = (r_s1_merge & r_s1_be[i]) ?
                                     r_s1_data[i*8 +: 8] : r_rd_word[i*8 +: 8];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_q     <= '0;
        end else begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_q <= w_s1_word;
            end
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic                  r_s3_valid;
        logic [DATA_WIDTH-1:0] r_s3_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_s3_valid <= 1'b0;
                r_s3_q     <= '0;
            end else begin
                r_s3_valid <= r_s2_valid;
                if (r_s2_valid) begin
                    r_s3_q <= r_s2_q;
                end
            end
        end

        assign q       = r_s3_q;
        assign q_valid = r_s3_valid;
    end else begin : g_out_direct
        assign q       = r_s2_q;
        assign q_valid = r_s2_valid;
    end

endmodule
`default_nettype wire

// File: tb/tb_sp_ram_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_sp_ram_param
// Brief    : Directed self-checking bench for sp_ram_param (16x16 instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sp_ram_param;

    logic        clk;
    logic        rst;
    logic        en;
    logic        we;
    logic [1:0]  be;
    logic [3:0]  addr;
    logic [15:0] data;

    // 0: read-first, 1: write-first, 2: no-change, 3: read-first + out reg,
    // 4: read-first without clear
    logic [15:0] q    [5];
    logic        qv   [5];
    logic        bsy  [5];

    int checks;
    int errors;
    int n;
    int nv;

    sp_ram_param #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .RD_MODE(0), .OUT_REG(0), .CLEAR_ON_RESET(1)) u_rd0 (
        .clk(clk), .rst(rst), .en(en), .we(we), .be(be), .addr(addr), .data(data),
        .q(q[0]), .q_valid(qv[0]), .busy(bsy[0]));
    sp_ram_param #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .RD_MODE(1), .OUT_REG(0), .CLEAR_ON_RESET(1)) u_rd1 (
        .clk(clk), .rst(rst), .en(en), .we(we), .be(be), .addr(addr), .data(data),
        .q(q[1]), .q_valid(qv[1]), .busy(bsy[1]));
    sp_ram_param #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .RD_MODE(2), .OUT_REG(0), .CLEAR_ON_RESET(1)) u_rd2 (
        .clk(clk), .rst(rst), .en(en), .we(we), .be(be), .addr(addr), .data(data),
        .q(q[2]), .q_valid(qv[2]), .busy(bsy[2]));
    sp_ram_param #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .RD_MODE(0), .OUT_REG(1), .CLEAR_ON_RESET(1)) u_oreg (
        .clk(clk), .rst(rst), .en(en), .we(we), .be(be), .addr(addr), .data(data),
        .q(q[3]), .q_valid(qv[3]), .busy(bsy[3]));
    sp_ram_param #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .RD_MODE(0), .OUT_REG(0), .CLEAR_ON_RESET(0)) u_noclr (
        .clk(clk), .rst(rst), .en(en), .we(we), .be(be), .addr(addr), .data(data),
        .q(q[4]), .q_valid(qv[4]), .busy(bsy[4]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic access(input logic w, input logic [3:0] a, input logic [15:0] d, input logic [1:0] b);
        en   = 1'b1;
        we   = w;
        addr = a;
        data = d;
        be   = b;
        tick();
        en   = 1'b0;
        we   = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1; en = 1'b0; we = 1'b0; be = 2'b00; addr = '0; data = '0;
        tick();
        tick();
        chk("rst_q", q[0], 16'h0000);
        chk("rst_qv", 16'(qv[0]), 16'd0);
        chk("rst_busy", 16'(bsy[0]), 16'd1);
        chk("rst_busy_noclr", 16'(bsy[4]), 16'd0);

        // Clear sequence with a write to addr 0 held on the bus throughout
        rst = 1'b0;
        en = 1'b1; we = 1'b1; addr = 4'd0; data = 16'hFFFF; be = 2'b11;
        n = 0; nv = 0;
        while (bsy[0] && n < 100) begin
            tick();
            n++;
            if (qv[0] || qv[1] || qv[3]) nv++;
        end
        en = 1'b0; we = 1'b0;
        chk("clr_busy_cycles", 16'(n), 16'd16);
        chk("lockout_qv", 16'(nv), 16'd0);

        // Read back every word; read-first results lag one edge
        nv = 0;
        for (int a = 0; a < 18; a++) begin
            if (a < 16) begin
                en = 1'b1; we = 1'b0; addr = 4'(a);
            end else begin
                en = 1'b0;
            end
            tick();
            if (qv[0]) nv++;
            if (a >= 1 && a <= 16) chk("clr_read", q[0], 16'h0000);
            if (a == 1) chk("noclr_addr0", q[4], 16'hFFFF);
            if (a >= 2) begin
                chk("clr_read_oreg", q[3], 16'h0000);
                chk("clr_read_oreg_qv", 16'(qv[3]), 16'd1);
            end
        end
        en = 1'b0;
        chk("clr_read_qv_count", 16'(nv), 16'd16);

        // Byte enables
        access(1'b1, 4'd3, 16'hABCD, 2'b11);
        access(1'b1, 4'd3, 16'h1234, 2'b01);
        access(1'b0, 4'd3, 16'h0000, 2'b00);
        chk("rdw_be_rd0", q[0], 16'hABCD);
        chk("rdw_be_rd1", q[1], 16'hAB34);
        chk("rdw_be_rd2_qv", 16'(qv[2]), 16'd0);
        tick();
        chk("be_rd0", q[0], 16'hAB34);
        chk("be_rd0_qv", 16'(qv[0]), 16'd1);
        chk("be_rd1", q[1], 16'hAB34);
        chk("be_rd2", q[2], 16'hAB34);
        tick();
        chk("be_oreg", q[3], 16'hAB34);
        chk("hold_q", q[0], 16'hAB34);
        chk("hold_qv", 16'(qv[0]), 16'd0);

        // Read-during-write
        access(1'b1, 4'd5, 16'h1111, 2'b11);
        tick();
        tick();
        access(1'b1, 4'd5, 16'h2222, 2'b11);
        tick();
        chk("rdw_rd0", q[0], 16'h1111);
        chk("rdw_rd0_qv", 16'(qv[0]), 16'd1);
        chk("rdw_rd1", q[1], 16'h2222);
        chk("rdw_rd1_qv", 16'(qv[1]), 16'd1);
        chk("rdw_rd2", q[2], 16'hAB34);
        chk("rdw_rd2_qv", 16'(qv[2]), 16'd0);

        // be=0 write: an access, but no update
        access(1'b1, 4'd5, 16'h3333, 2'b00);
        tick();
        chk("be0_rd0", q[0], 16'h2222);
        chk("be0_rd1", q[1], 16'h2222);
        access(1'b0, 4'd5, 16'h0000, 2'b00);
        tick();
        chk("be0_read", q[0], 16'h2222);

        // Output-register latency and throughput
        access(1'b1, 4'd0, 16'h0A0A, 2'b11);
        access(1'b1, 4'd1, 16'h1B1B, 2'b11);
        access(1'b1, 4'd2, 16'h2C2C, 2'b11);
        tick();
        tick();
        tick();
        access(1'b0, 4'd0, 16'h0000, 2'b00);
        access(1'b0, 4'd1, 16'h0000, 2'b00);
        chk("lat_n1_qv", 16'(qv[3]), 16'd0);
        access(1'b0, 4'd2, 16'h0000, 2'b00);
        chk("lat_n2_q", q[3], 16'h0A0A);
        chk("lat_n2_qv", 16'(qv[3]), 16'd1);
        tick();
        chk("lat_n3_q", q[3], 16'h1B1B);
        chk("lat_n3_qv", 16'(qv[3]), 16'd1);
        tick();
        chk("lat_n4_q", q[3], 16'h2C2C);
        chk("lat_n4_qv", 16'(qv[3]), 16'd1);
        tick();
        chk("lat_n5_qv", 16'(qv[3]), 16'd0);
        chk("lat_n5_hold", q[3], 16'h2C2C);

        // Reset flushes an in-flight read, then reset again mid-clear
        access(1'b0, 4'd1, 16'h0000, 2'b00);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("flush_qv_a", 16'(qv[3]), 16'd0);
        chk("flush_q", q[3], 16'h0000);
        tick();
        chk("flush_qv_b", 16'(qv[3]), 16'd0);
        for (int i = 0; i < 6; i++) tick();
        chk("midclr_busy", 16'(bsy[0]), 16'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n = 0;
        while (bsy[0] && n < 100) begin
            tick();
            n++;
        end
        chk("midclr_busy_cycles", 16'(n), 16'd16);
        access(1'b0, 4'd2, 16'h0000, 2'b00);
        tick();
        chk("midclr_read", q[0], 16'h0000);
        chk("midclr_read_qv", 16'(qv[0]), 16'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
